fwrisc_uart_rx: RTL and testbench

- Serial receiver that consumes the `tx` line driven by `fwrisc_fpga_top`.
- Recovers 8N1 UART frames and buffers the decoded bytes in a small FIFO.
- Presents bytes on a valid/ready interface so the FPGA testbench can check firmware console output cycle-accurately.
- Also synthesisable, so it can serve as the on-FPGA loopback receiver.

---
 rtl/fwrisc_uart_pkg.sv | 22 ++
 rtl/fwrisc_uart_rx_fifo.sv | 78 +++++++
 rtl/fwrisc_uart_rx.sv | 171 +++++++++++++++++
 tb/tb_fwrisc_uart_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fwrisc_uart_pkg.sv
// Shared types and helpers for the fwrisc UART blocks.
//   rx_state_e           : receiver FSM states
//   DEFAULT_CLKS_PER_BIT : 50 MHz / 115200 baud
//   cnt_width()          : width of a down-counter that must hold n-1
package fwrisc_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    // Never narrower than one bit, even for tiny divisors.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fwrisc_uart_rx_fifo.sv
// Small first-word-fall-through FIFO with a registered head word.
//   clock, reset_n : clock and async active-low reset
//   push/push_data : write request and data (accepted if not full, or if a pop
//                    happens in the same cycle)
//   pop            : read request (ignored when empty)
//   head           : current head-of-FIFO word (0 after reset)
//   full, empty    : registered status flags
module fwrisc_uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic             do_pop_c;
    logic             do_push_c;
    logic [PW-1:0]    rd_ptr_nxt_c;
    logic [CW-1:0]    count_nxt_c;

    // Qualified push/pop and next-state values.
    always_comb begin
        do_pop_c     = pop && (count != '0);
        do_push_c    = push && ((count != CW'(DEPTH)) || do_pop_c);
        rd_ptr_nxt_c = do_pop_c ? PW'(rd_ptr + PW'(1)) : rd_ptr;
        count_nxt_c  = count;
        if (do_push_c && !do_pop_c) begin
            count_nxt_c = CW'(count + CW'(1));
        end else if (!do_push_c && do_pop_c) begin
            count_nxt_c = CW'(count - CW'(1));
        end
    end

    // Storage, pointers, and a head register that tracks the next read slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push_c) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= PW'(wr_ptr + PW'(1));
            end
            rd_ptr <= rd_ptr_nxt_c;
            count  <= count_nxt_c;
            full   <= (count_nxt_c == CW'(DEPTH));
            empty  <= (count_nxt_c == '0);
            // A word written into the slot about to become head bypasses mem.
            if (do_push_c && (wr_ptr == rd_ptr_nxt_c)) begin
                head <= push_data;
            end else begin
                head <= mem[rd_ptr_nxt_c];
            end
        end
    end

endmodule

// File: rtl/fwrisc_uart_rx.sv
// 8N1 UART receiver with a small byte FIFO and valid/ready output.
//   clock, reset_n : clock and async active-low reset
//   rx_i           : serial line, idle high, asynchronous to clock
//   data_o/valid_o : head-of-FIFO byte and non-empty flag
//   ready_i        : consumer takes data_o when valid_o && ready_i
//   busy_o         : a frame is being received
//   frame_err_o    : sticky, stop bit sampled low
//   overrun_o      : sticky, byte dropped because FIFO was full
//   clr_i          : clears the sticky flags (a coincident set wins)
module fwrisc_uart_rx
    import fwrisc_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 busy_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    input  logic                 clr_i
);

    localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS + 1);

    logic                 rx_meta;
    logic                 rx_s;
    rx_state_e            state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 stop_tick_c;
    logic                 push_c;
    logic                 pop_c;
    logic                 ferr_set_c;
    logic                 ovr_set_c;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM: sample mid-bit using a down-counter reloaded every bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            busy_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        cnt    <= CW'(CLKS_PER_BIT / 2 - 1);
                        busy_o <= 1'b1;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= CW'(cnt - CW'(1));
                    end else if (!rx_s) begin
                        state <= DATA;
                        cnt   <= CW'(CLKS_PER_BIT - 1);
                        idx   <= '0;
                    end else begin
                        // Start bit did not survive to mid-bit: a glitch.
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= CW'(cnt - CW'(1));
                    end else begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        cnt   <= CW'(CLKS_PER_BIT - 1);
                        if (idx == IW'(DATA_BITS - 1)) begin
                            state <= STOP;
                        end else begin
                            idx <= IW'(idx + IW'(1));
                        end
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= CW'(cnt - CW'(1));
                    end else if (rx_s) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        state <= BREAK;
                    end
                end
                BREAK: begin
                    // Hold off until the line returns high so a held-low
                    // line is not mistaken for a new start bit.
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Push on a good stop sample; flag a drop when the FIFO cannot take it.
    always_comb begin
        stop_tick_c = (state == STOP) && (cnt == '0);
        push_c      = stop_tick_c && rx_s;
        ferr_set_c  = stop_tick_c && !rx_s;
        pop_c       = valid_o && ready_i;
        ovr_set_c   = push_c && fifo_full && !pop_c;
    end

    // Sticky error flags; set has priority over clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (ferr_set_c) begin
                frame_err_o <= 1'b1;
            end else if (clr_i) begin
                frame_err_o <= 1'b0;
            end
            if (ovr_set_c) begin
                overrun_o <= 1'b1;
            end else if (clr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

    fwrisc_uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push_c),
        .push_data (shreg),
        .pop       (pop_c),
        .head      (data_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign valid_o = !fifo_empty;

endmodule

// File: tb/tb_fwrisc_uart_rx.sv
// Self-checking bench for fwrisc_uart_rx at 8 clocks per bit.
// Stimulus pushes expected bytes into a queue; a monitor pops and compares
// every accepted output byte.
module tb_fwrisc_uart_rx;

    localparam int unsigned CPB = 8;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_i    = 1'b1;
    logic       ready_i = 1'b0;
    logic       clr_i   = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       busy_o;
    logic       frame_err_o;
    logic       overrun_o;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         valid_rise_cyc = -1;
    logic       valid_q = 1'b0;
    logic       busy_mid = 1'b0;
    logic [7:0] exp_q [$];

    fwrisc_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .FIFO_DEPTH   (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .clr_i       (clr_i)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_i = v;
        tick(CPB);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(b[i]);
            if (i == 3) busy_mid = busy_o;
        end
        drive_bit(stop);
    endtask

    // Scoreboard monitor: sample between edges, compare each accepted byte.
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clock);
            if (valid_o && !valid_q) valid_rise_cyc = cyc;
            valid_q = valid_o;
            if (reset_n && valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected none", data_o);
                end else begin
                    exp = exp_q.pop_front();
                    check("rx_byte", int'(data_o), int'(exp));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int d;
        int bc;

        // Reset values
        tick(3);
        check("rst_valid", int'(valid_o), 0);
        check("rst_data", int'(data_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_ferr", int'(frame_err_o), 0);
        check("rst_ovr", int'(overrun_o), 0);
        reset_n = 1'b1;
        tick(5);

        // Single 0x55 frame with latency check
        ready_i = 1'b1;
        exp_q.push_back(8'h55);
        valid_rise_cyc = -1;
        t0 = cyc;
        send(8'h55, 1'b1);
        tick(4);
        d = valid_rise_cyc - t0;
        check("latency_78_80", int'(d >= 78 && d <= 80), 1);
        check("busy_mid_frame", int'(busy_mid), 1);
        check("busy_after", int'(busy_o), 0);
        check("t1_ferr", int'(frame_err_o), 0);
        check("t1_ovr", int'(overrun_o), 0);

        // Two-cycle glitch
        rx_i = 1'b0;
        tick(2);
        rx_i = 1'b1;
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (busy_o) bc++;
        end
        check("glitch_busy_le6", int'(bc > 0 && bc <= 6), 1);
        check("glitch_valid", int'(valid_o), 0);
        check("glitch_ferr", int'(frame_err_o), 0);

        // Bad stop bit on 0xA5, held low, then good 0x3C
        drive_bit(1'b0);
        begin
            logic [7:0] b;
            b = 8'hA5;
            for (int i = 0; i < 8; i++) drive_bit(b[i]);
        end
        rx_i = 1'b0;
        tick(3 * CPB);
        rx_i = 1'b1;
        tick(2 * CPB);
        check("ferr_set", int'(frame_err_o), 1);
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b1);
        tick(4);
        check("ferr_sticky", int'(frame_err_o), 1);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        check("ferr_cleared", int'(frame_err_o), 0);

        // Five frames into a four-entry FIFO with no consumer
        ready_i = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            if (v <= 4) exp_q.push_back(8'(v));
            send(8'(v), 1'b1);
        end
        tick(10);
        check("ovr_set", int'(overrun_o), 1);
        check("ovr_valid", int'(valid_o), 1);
        check("ovr_head", int'(data_o), 1);
        ready_i = 1'b1;
        tick(10);
        check("ovr_drained", int'(valid_o), 0);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        check("ovr_cleared", int'(overrun_o), 0);

        // Full FIFO with a pop landing on the push cycle of 0x77
        ready_i = 1'b0;
        exp_q.push_back(8'h11);
        send(8'h11, 1'b1);
        exp_q.push_back(8'h22);
        send(8'h22, 1'b1);
        exp_q.push_back(8'h33);
        send(8'h33, 1'b1);
        exp_q.push_back(8'h44);
        send(8'h44, 1'b1);
        exp_q.push_back(8'h77);
        drive_bit(1'b0);
        begin
            logic [7:0] b;
            b = 8'h77;
            for (int i = 0; i < 8; i++) drive_bit(b[i]);
        end
        rx_i = 1'b1;
        tick(CPB - 2);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
        tick(1);
        tick(4);
        check("coincide_no_ovr", int'(overrun_o), 0);
        check("coincide_valid", int'(valid_o), 1);
        ready_i = 1'b1;
        tick(10);
        check("coincide_drained", int'(valid_o), 0);

        // Reset during data bit 3 of 0xFF with a byte left in the FIFO
        ready_i = 1'b0;
        send(8'h99, 1'b1);
        tick(2);
        check("pre_rst_valid", int'(valid_o), 1);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rx_i = 1'b1;
        tick(CPB / 2);
        reset_n = 1'b0;
        #2;
        check("midrst_valid", int'(valid_o), 0);
        check("midrst_data", int'(data_o), 0);
        check("midrst_busy", int'(busy_o), 0);
        check("midrst_ferr", int'(frame_err_o), 0);
        check("midrst_ovr", int'(overrun_o), 0);
        tick(1);
        reset_n = 1'b1;
        tick(CPB / 2 - 1);
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        ready_i = 1'b1;
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b1);
        tick(10);
        check("post_rst_valid", int'(valid_o), 0);
        check("post_rst_ferr", int'(frame_err_o), 0);
        check("post_rst_ovr", int'(overrun_o), 0);

        // Drain with a bounded wait
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
